pe_array_tf: RTL and testbench

- Parametrised successor to the fixed 8x4 PE block: a ROWS x TAPS transposed-form MAC array.
- One activation stream is broadcast to every PE. Each row chains its partial sums through TAPS stages with per-tap weights, so every row computes a TAPS-deep dot product over the most recent samples plus a bias.
- Adds a runtime weight/bias write port, valid/ready streaming with backpressure, frame-based history clearing, a signed/unsigned mode, ReLU and output saturation.
- Sits between the activation buffer and the output writeback in the int8 datapath.

---
 rtl/pe_array_tf.sv | 128 ++++++++++++
 tb/tb_pe_array_tf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_tf.sv
// ROWS x TAPS transposed-form MAC array: one broadcast activation stream, per-row
// partial-sum chains, runtime weight/bias port, valid/ready output register.
// Requires TAPS >= 2.
module pe_array_tf #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned TAPS  = 4,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic [$clog2(ROWS*(TAPS+1))-1:0]   cfg_addr,
  input  logic [ACC_W-1:0]                   cfg_data,
  output logic                               cfg_err,
  input  logic                               mode_signed,
  input  logic                               mode_relu,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ROWS*OUT_W-1:0]              out_data,
  output logic                               out_last
);

  localparam int unsigned AW   = $clog2(ROWS*(TAPS+1));
  localparam int unsigned NCFG = ROWS*(TAPS+1);
  localparam int unsigned PW   = 2*IN_W + 2;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [IN_W-1:0]  w       [ROWS][TAPS];
  logic [ACC_W-1:0] bias    [ROWS];
  logic [ACC_W-1:0] p       [ROWS][TAPS-1];
  logic [ACC_W-1:0] p_in    [ROWS][TAPS];
  logic [ACC_W-1:0] prod    [ROWS][TAPS];
  logic [ACC_W-1:0] row_sum [ROWS];
  logic             frame_active;
  logic             accept;
  logic             busy;
  logic             addr_ok;

  // Sign/zero-extended IN_W x IN_W product, widened to the accumulator.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [IN_W-1:0] a,
                                               input logic [IN_W-1:0] b,
                                               input logic            sgn);
    logic signed [IN_W:0] ae;
    logic signed [IN_W:0] be;
    logic signed [PW-1:0] pr;
    ae = {sgn & a[IN_W-1], a};
    be = {sgn & b[IN_W-1], b};
    pr = PW'(ae) * PW'(be);
    return ACC_W'(pr);
  endfunction

  // Optional ReLU, then clamp into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] out_stage(input logic [ACC_W-1:0] v,
                                                 input logic             relu);
    logic signed [ACC_W-1:0] s;
    logic [OUT_W-1:0]        res;
    s = v;
    if (relu && s[ACC_W-1]) s = '0;
    if (s > OUT_MAX)      res = OUT_W'(OUT_MAX);
    else if (s < OUT_MIN) res = OUT_W'(OUT_MIN);
    else                  res = OUT_W'(s);
    return res;
  endfunction

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = frame_active || out_valid || accept;
  assign addr_ok  = 32'(cfg_addr) < NCFG;

  // Products for the broadcast sample; p_in pads the chain end with zero.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < TAPS; k++) begin
        prod[r][k] = mul_ext(w[r][k], in_data, mode_signed);
        p_in[r][k] = '0;
      end
      for (int k = 0; k < TAPS - 1; k++) p_in[r][k] = p[r][k];
      row_sum[r] = bias[r] + prod[r][0] + p_in[r][0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        bias[r] <= '0;
        for (int k = 0; k < TAPS; k++)     w[r][k] <= '0;
        for (int k = 0; k < TAPS - 1; k++) p[r][k] <= '0;
      end
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      cfg_err      <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (busy || !addr_ok);

      // Writes land only while idle; the address walk avoids a divider.
      if (cfg_we && !busy && addr_ok) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int k = 0; k < TAPS; k++)
            if (cfg_addr == AW'(r*(TAPS+1) + k)) w[r][k] <= cfg_data[IN_W-1:0];
          if (cfg_addr == AW'(r*(TAPS+1) + TAPS)) bias[r] <= cfg_data;
        end
      end

      if (accept) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int k = 0; k < TAPS - 1; k++)
            p[r][k] <= in_last ? '0 : p_in[r][k+1] + prod[r][k+1];
          out_data[r*OUT_W +: OUT_W] <= out_stage(row_sum[r], mode_relu);
        end
        out_last     <= in_last;
        out_valid    <= 1'b1;
        frame_active <= !in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_tf.sv
// Bench for pe_array_tf: directed scenarios plus random traffic, checked every cycle
// against a history-based dot-product model.
module tb_pe_array_tf;

  localparam int ROWS  = 8;
  localparam int TAPS  = 4;
  localparam int OUT_W = 16;
  localparam int AW    = $clog2(ROWS*(TAPS+1));
  localparam int NCFG  = ROWS*(TAPS+1);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cfg_we = 1'b0;
  logic [AW-1:0]           cfg_addr = '0;
  logic [31:0]             cfg_data = '0;
  logic                    cfg_err;
  logic                    mode_signed = 1'b1;
  logic                    mode_relu = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [7:0]              in_data = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [ROWS*OUT_W-1:0]   out_data;
  logic                    out_last;

  pe_array_tf dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .mode_signed(mode_signed), .mode_relu(mode_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Reference state: configuration, frame history (newest first), pending output.
  int  mw [ROWS][TAPS];
  int  mb [ROWS];
  int  hist [$];
  int  od_m [ROWS];
  bit  act_m, ov_m, ol_m, err_m, acc_now;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ext(input int v, input bit sg);
    int t;
    t = v & 255;
    if (sg && t > 127) t -= 256;
    return t;
  endfunction

  function automatic int sat(input int s, input bit relu);
    int t;
    t = s;
    if (relu && t < 0) t = 0;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  function automatic logic [15:0] row_of(input int r);
    return out_data[r*OUT_W +: OUT_W];
  endfunction

  // One clock: compare DUT to model at negedge, advance model, return at posedge+1.
  task automatic tick();
    logic [127:0] exp_d;
    bit           rdy_m, busy_m;
    longint       acc;
    int           row, idx;
    @(negedge clk);
    rdy_m = !rst && (!ov_m || out_ready);
    check("out_valid", out_valid, ov_m);
    check("in_ready", in_ready, rdy_m);
    check("cfg_err", cfg_err, err_m);
    if (ov_m) begin
      exp_d = '0;
      for (int r = 0; r < ROWS; r++) exp_d[r*OUT_W +: OUT_W] = 16'(od_m[r]);
      check("out_data", out_data, exp_d);
      check("out_last", out_last, ol_m);
    end
    acc_now = in_valid && rdy_m;
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        mb[r] = 0;
        od_m[r] = 0;
        for (int k = 0; k < TAPS; k++) mw[r][k] = 0;
      end
      hist.delete();
      act_m = 0; ov_m = 0; ol_m = 0; err_m = 0;
    end else begin
      busy_m = act_m || ov_m || acc_now;
      if (acc_now) begin
        hist.push_front(int'(in_data));
        if (hist.size() > TAPS) void'(hist.pop_back());
        for (int r = 0; r < ROWS; r++) begin
          acc = longint'(mb[r]);
          for (int k = 0; k < hist.size(); k++)
            acc += longint'(ext(mw[r][k], mode_signed) * ext(hist[k], mode_signed));
          od_m[r] = sat(int'(acc), mode_relu);
        end
        ol_m  = in_last;
        ov_m  = 1;
        act_m = !in_last;
        if (in_last) hist.delete();
      end else if (out_ready) begin
        ov_m = 0;
      end
      err_m = 0;
      if (cfg_we) begin
        if (busy_m || int'(cfg_addr) >= NCFG) begin
          err_m = 1;
        end else begin
          row = int'(cfg_addr) / (TAPS+1);
          idx = int'(cfg_addr) % (TAPS+1);
          if (idx < TAPS) mw[row][idx] = int'(cfg_data) & 255;
          else            mb[row] = int'(cfg_data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 0; cfg_we = 0; out_ready = 1;
    repeat (n) tick();
  endtask

  task automatic cfg(input int addr, input logic [31:0] d);
    in_valid = 0; cfg_we = 1; cfg_addr = AW'(addr); cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic send(input int x, input bit last);
    in_valid = 1; in_data = 8'(x); in_last = last; out_ready = 1;
    tick();
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    int t1 [5];
    int nx, cyc;
    t1 = '{11, 13, 16, 20, 20};

    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 0;

    // Row 0 weights 1..4, bias 10, constant stream of ones.
    cfg(0, 1); cfg(1, 2); cfg(2, 3); cfg(3, 4); cfg(4, 10);
    for (int i = 0; i < 5; i++) begin
      send(1, i == 4);
      check("t1_row0", row_of(0), 16'(t1[i]));
      check("t1_last", out_last, i == 4);
    end
    send(2, 1);
    check("t2_row0", row_of(0), 12);
    check("t2_row1", row_of(1), 0);
    idle_cycles(1);

    // Backpressure with in_valid held, sequence 1..5.
    nx = 0; cyc = 0;
    while (nx < 5 && cyc < 50) begin
      in_valid = 1; in_data = 8'(nx + 1); in_last = (nx == 4);
      out_ready = !(cyc >= 2 && cyc <= 4);
      tick();
      if (acc_now) nx++;
      cyc++;
    end
    check("t3_all_accepted", nx, 5);
    check("t3_row0_last", row_of(0), 40);
    in_valid = 0; in_last = 0;
    idle_cycles(2);

    // Saturation: signed -128*127, then ReLU, then unsigned 255*255.
    for (int a = 0; a < NCFG; a++) cfg(a, (a % (TAPS+1) < TAPS) ? 32'hFFFF_FF80 : 32'h0);
    for (int i = 0; i < 4; i++) send(127, i == 3);
    check("t4_sat_neg", row_of(0), 16'h8000);
    idle_cycles(1);
    mode_relu = 1;
    for (int i = 0; i < 4; i++) send(127, i == 3);
    check("t4_relu", row_of(3), 16'h0000);
    idle_cycles(1);
    mode_relu = 0; mode_signed = 0;
    for (int a = 0; a < NCFG; a++) cfg(a, (a % (TAPS+1) < TAPS) ? 32'd255 : 32'h0);
    for (int i = 0; i < 4; i++) send(255, i == 3);
    check("t4_sat_pos", row_of(0), 16'h7FFF);
    idle_cycles(1);

    // Config rejected mid-frame, accepted once idle, out-of-range rejected.
    mode_signed = 1;
    send(1, 0);
    cfg(0, 5);
    check("t5_err_busy", cfg_err, 1);
    send(1, 1);
    check("t5_err_clear", cfg_err, 0);
    check("t5_old_weight", row_of(0), 16'hFFFE);
    idle_cycles(1);
    cfg(0, 5);
    check("t5_err_idle", cfg_err, 0);
    cfg(45, 7);
    check("t5_err_range", cfg_err, 1);
    send(1, 1);
    check("t5_new_weight", row_of(0), 5);
    idle_cycles(1);

    // Reset while an output is pending mid-frame.
    send(3, 0);
    rst = 1; in_valid = 1; in_data = 8'd4; out_ready = 0;
    tick();
    check("t6_out_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 0);
    rst = 0; in_valid = 0; out_ready = 1;
    tick();
    for (int i = 0; i < 4; i++) send(i + 7, i == 3);
    check("t6_row0_zero", row_of(0), 0);
    check("t6_row5_zero", row_of(5), 0);
    idle_cycles(1);

    // Random traffic with idle windows so some writes land.
    for (int c = 0; c < 600; c++) begin
      if (!act_m && !ov_m && $urandom_range(0, 9) == 0) begin
        mode_signed = 1'($urandom);
        mode_relu   = 1'($urandom);
      end
      in_valid  = (c % 50 < 40) && ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_addr  = AW'($urandom_range(0, 47));
      cfg_data  = $urandom;
      tick();
    end
    in_valid = 0; cfg_we = 0;
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
